nrisc_control: RTL and testbench
================================

// Module: nrisc_control
// PURPOSE
//  Multi-cycle control unit of the 8-bit Nrisc processor, directly upstream of the register bank.
//  Fetches instructions and optional immediate bytes, decodes them, and drives the bank read/write
//  addresses and write enable. Also drives ALU op, data-memory strobes and the program counter.
//  Sequencing: fetch/decode/execute/memory/writeback FSM with ready handshakes on both memories.
// PARAMETERS
//  PC_W      8  program counter width; wraps modulo 2^PC_W
//  RESET_PC  0  PC value loaded on reset
// PORTS
//  clk          in   1  system clock, all state on rising edge
//  rst_n        in   1  asynchronous active-low reset
//  instr        in   8  byte from instruction memory: op[7:4] ra[3:2] rb[1:0]
//  instr_valid  in   1  instr holds the byte at pc this cycle
//  mem_ready    in   1  data memory completed current read/write
//  alu_zero     in   1  ALU zero flag (ra - rb == 0), sampled in EXEC
//  instr_req    out  1  request byte at pc
//  pc           out  PC_W  program counter
//  rd_addr1     out  2  register bank read port 1 (= ra)
//  rd_addr2     out  2  register bank read port 2 (= rb)
//  wr_addr      out  3  register bank write address
//  wr_en        out  1  register bank write enable, one cycle in WB
//  wb_sel       out  2  writeback source: 0 ALU, 1 memory, 2 immediate, 3 read port 2
//  alu_op       out  3  0 ADD 1 SUB 2 AND 3 OR 4 SLT
//  imm          out  8  latched immediate byte
//  mem_rd       out  1  data memory read strobe, held until mem_ready
//  mem_wr       out  1  data memory write strobe, held until mem_ready
//  halted       out  1  HALT executed; sticky until reset
//  illegal      out  1  one-cycle pulse in DECODE for unused opcode (then executed as NOP)
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, IR=0, imm=0. Every output is 0 except pc. Reset is honoured
//   mid-fetch or mid-memory access; the pending request is dropped with no write.
//  Opcodes: 0-4 ALU ra<-ra op rb; 5 LW ra<-M[rb]; 6 SW M[rb]<-ra; 7 BEQ imm; 8 LI ra<-imm;
//   9 JMP imm; A MVH r{4+ra}<-rb; F HALT; B-E illegal.
//  States and transitions:
//   IDLE  -> FETCH, unconditionally, first cycle after reset release.
//   FETCH: instr_req=1; on instr_valid latch IR, pc<=pc+1 -> DECODE; else stay.
//   DECODE: rd_addr1/2 driven from IR and held stable through WB, because the bank reads on the
//    falling edge. BEQ/LI/JMP -> FIMM; HALT -> HALT; illegal -> FETCH; else EXEC.
//   FIMM: instr_req=1; on instr_valid latch imm, pc<=pc+1 -> EXEC.
//   EXEC: alu_op valid. JMP sets pc<=imm. BEQ sets pc<=imm if alu_zero.
//    JMP/BEQ -> FETCH; LW/SW -> MEM; others -> WB.
//   MEM: mem_rd (LW) or mem_wr (SW) held; on mem_ready, LW -> WB and SW -> FETCH.
//   WB: wr_en=1 for exactly one cycle -> FETCH.
//    wr_addr={1'b0,ra}, or {1'b1,ra} for MVH. wb_sel per opcode.
//   HALT: halted=1; no requests; leave only by reset.
//  Timing: ALU ops take 4 cycles with zero-wait memories; LI/JMP/BEQ take 4-5 cycles.
//  pc wraps 0xFF->0x00 with no flag, including during FIMM.
//  A taken branch or jump overrides the increment.
//  instr_valid outside FETCH/FIMM, and mem_ready outside MEM, are ignored.
//  wr_en and mem_wr are never asserted in the same cycle.
// STRUCTURE
//  nrisc_defs.vh (shared include): opcode, ALU op, wb_sel and state encodings, instr field slices.
//  Sub-module nrisc_decoder (combinational IR -> alu_op, wb_sel, needs_imm, is_mem, illegal).
//  This module keeps the FSM, pc, IR, imm and the handshake logic.
// TESTING
//  1 Reset mid-FETCH (rst_n low 3 cycles while instr_req=1) -> pc=0, all outputs 0, IDLE->FETCH.
//  2 Program 0x01 ADD r0,r1 -> rd_addr1=0, rd_addr2=1, alu_op=0, wr_en=1 wr_addr=0 on cycle 4.
//  3 LI 0x88,0x2A then MVH 0xA6 (ra=1,rb=2) -> imm=0x2A wb_sel=2 wr_addr=2; then wr_addr=5 wb_sel=3.
//  4 LW 0x51 with mem_ready delayed 3 cycles -> mem_rd held 4 cycles, then one wr_en, wb_sel=1.
//  5 BEQ 0x70,0x40: alu_zero=1 gives pc=0x40; alu_zero=0 gives pc=old+2.
//    pc=0xFF fetch wraps to 0x00.
//  6 Opcode 0xC3 -> illegal pulse, no wr_en/mem strobes. Then 0xF0 -> halted=1, instr_req stays 0.

Source files
------------

// File: rtl/nrisc_control_pkg.sv
// Nrisc control unit shared types: opcodes, ALU ops, writeback sources,
// FSM states, decoded-control bundle and instruction field helpers.
package nrisc_control_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_SLT  = 4'h4,
    OP_LW   = 4'h5,
    OP_SW   = 4'h6,
    OP_BEQ  = 4'h7,
    OP_LI   = 4'h8,
    OP_JMP  = 4'h9,
    OP_MVH  = 4'hA,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_IMM = 2'd2,
    WB_RB  = 2'd3
  } wb_sel_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_FIMM,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef struct packed {
    alu_op_e alu_op;
    wb_sel_e wb_sel;
    logic    needs_imm;
    logic    is_mem;
    logic    illegal;
  } dec_t;

  function automatic logic [3:0] ir_op(input logic [7:0] ir);
    return ir[7:4];
  endfunction

  function automatic logic [1:0] ir_ra(input logic [7:0] ir);
    return ir[3:2];
  endfunction

  function automatic logic [1:0] ir_rb(input logic [7:0] ir);
    return ir[1:0];
  endfunction

endpackage

// File: rtl/nrisc_control_decoder.sv
// Nrisc instruction decoder: purely combinational IR -> control bundle.
// Opcodes B..E are flagged illegal and otherwise decode as a NOP.
module nrisc_control_decoder
  import nrisc_control_pkg::*;
(
  input  logic [7:0] ir,
  output dec_t       dec
);

  logic [3:0] op;

  assign op = ir_op(ir);

  always_comb begin
    dec = '0;
    unique case (1'b1)
      (op <= OP_SLT): begin
        dec.alu_op = alu_op_e'(op[2:0]);
      end
      (op == OP_LW): begin
        dec.wb_sel = WB_MEM;
        dec.is_mem = 1'b1;
      end
      (op == OP_SW): begin
        dec.is_mem = 1'b1;
      end
      (op == OP_BEQ): begin
        // zero flag of ra - rb decides the branch
        dec.alu_op    = ALU_SUB;
        dec.needs_imm = 1'b1;
      end
      (op == OP_LI): begin
        dec.wb_sel    = WB_IMM;
        dec.needs_imm = 1'b1;
      end
      (op == OP_JMP): begin
        dec.needs_imm = 1'b1;
      end
      (op == OP_MVH): begin
        dec.wb_sel = WB_RB;
      end
      (op == OP_HALT): begin
        dec.illegal = 1'b0;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/nrisc_control.sv
// Nrisc multi-cycle control unit: fetch/decode/exec/mem/wb FSM,
// program counter, instruction and immediate registers.
module nrisc_control
  import nrisc_control_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      instr,
  input  logic            instr_valid,
  input  logic            mem_ready,
  input  logic            alu_zero,
  output logic            instr_req,
  output logic [PC_W-1:0] pc,
  output logic [1:0]      rd_addr1,
  output logic [1:0]      rd_addr2,
  output logic [2:0]      wr_addr,
  output logic            wr_en,
  output logic [1:0]      wb_sel,
  output logic [2:0]      alu_op,
  output logic [7:0]      imm,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            halted,
  output logic            illegal
);

  state_e     state_q;
  state_e     state_d;
  logic [7:0] ir;
  logic [3:0] op;
  dec_t       dec;
  logic       is_lw;
  logic       is_sw;
  logic       is_jmp;
  logic       is_beq;
  logic       take;

  nrisc_control_decoder u_dec (
    .ir  (ir),
    .dec (dec)
  );

  assign op     = ir_op(ir);
  assign is_lw  = (op == OP_LW);
  assign is_sw  = (op == OP_SW);
  assign is_jmp = (op == OP_JMP);
  assign is_beq = (op == OP_BEQ);
  assign take   = is_jmp || (is_beq && alu_zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (instr_valid) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (dec.illegal) state_d = S_FETCH;
        else if (op == OP_HALT) state_d = S_HALT;
        else if (dec.needs_imm) state_d = S_FIMM;
        else state_d = S_EXEC;
      end
      S_FIMM: begin
        if (instr_valid) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_jmp || is_beq) state_d = S_FETCH;
        else if (dec.is_mem) state_d = S_MEM;
        else state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ready) state_d = is_lw ? S_WB : S_FETCH;
      end
      S_WB: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // a taken branch or jump in EXEC overrides any earlier increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= RESET_PC;
      ir  <= '0;
      imm <= '0;
    end else begin
      if (state_q == S_FETCH && instr_valid) begin
        ir <= instr;
        pc <= pc + PC_W'(1);
      end
      if (state_q == S_FIMM && instr_valid) begin
        imm <= instr;
        pc  <= pc + PC_W'(1);
      end
      if (state_q == S_EXEC && take) begin
        pc <= PC_W'(imm);
      end
    end
  end

  // read addresses come straight from IR so they hold from DECODE to WB
  assign rd_addr1  = ir_ra(ir);
  assign rd_addr2  = ir_rb(ir);
  assign wr_addr   = {(op == OP_MVH), ir_ra(ir)};
  assign wb_sel    = dec.wb_sel;
  assign alu_op    = dec.alu_op;

  assign instr_req = (state_q == S_FETCH) || (state_q == S_FIMM);
  assign wr_en     = (state_q == S_WB);
  assign mem_rd    = (state_q == S_MEM) && is_lw;
  assign mem_wr    = (state_q == S_MEM) && is_sw;
  assign halted    = (state_q == S_HALT);
  assign illegal   = (state_q == S_DECODE) && dec.illegal;

endmodule

// File: tb/tb_nrisc_control.sv
// Bench for nrisc_control: directed program steps plus randomized
// instructions checked against an instruction-level outcome model.
module tb_nrisc_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] instr = 8'h00;
  logic       instr_valid = 1'b0;
  logic       mem_ready = 1'b0;
  logic       alu_zero = 1'b0;
  logic       instr_req;
  logic [7:0] pc;
  logic [1:0] rd_addr1;
  logic [1:0] rd_addr2;
  logic [2:0] wr_addr;
  logic       wr_en;
  logic [1:0] wb_sel;
  logic [2:0] alu_op;
  logic [7:0] imm;
  logic       mem_rd;
  logic       mem_wr;
  logic       halted;
  logic       illegal;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] mpc = 8'h00;

  always #5 clk = ~clk;

  nrisc_control #(
    .PC_W     (8),
    .RESET_PC (8'h00)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .mem_ready   (mem_ready),
    .alu_zero    (alu_zero),
    .instr_req   (instr_req),
    .pc          (pc),
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .wr_addr     (wr_addr),
    .wr_en       (wr_en),
    .wb_sel      (wb_sel),
    .alu_op      (alu_op),
    .imm         (imm),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .halted      (halted),
    .illegal     (illegal)
  );

  function automatic logic [25:0] outs();
    return {instr_req, rd_addr1, rd_addr2, wr_addr, wr_en, wb_sel,
            alu_op, imm, mem_rd, mem_wr, halted, illegal};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk({nm, ".async_pc"}, 32'(pc), 32'h0);
    chk({nm, ".async_outs"}, 32'(outs()), 32'h0);
    repeat (3) tick();
    chk({nm, ".pc"}, 32'(pc), 32'h0);
    chk({nm, ".outs"}, 32'(outs()), 32'h0);
    rst_n = 1'b1;
    chk({nm, ".idle_req"}, 32'(instr_req), 32'h0);
    tick();
    chk({nm, ".fetch_req"}, 32'(instr_req), 32'h1);
    mpc = 8'h00;
  endtask

  // Runs one instruction from its first FETCH cycle to the next FETCH
  task automatic exec_one(input string nm, input logic [7:0] b0,
                          input logic [7:0] b1, input bit z,
                          input int fw, input int md);
    int op, ra, rb, len;
    int ecyc, ewr, ewa, ews, erd, emw, eill, ehalt, ealu, eidx;
    logic [7:0] npc;
    logic [7:0] bytes [2];
    int cyc, k, wcnt, mcnt;
    int nwr, nrd, nmw, nil, nov, nbad, wa, ws, im, aluo;
    op = int'(b0[7:4]);
    ra = int'(b0[3:2]);
    rb = int'(b0[1:0]);
    bytes[0] = b0;
    bytes[1] = b1;
    len = (op == 7 || op == 8 || op == 9) ? 2 : 1;
    npc = mpc + 8'(len);
    ewr = 0; ewa = ra; ews = 0; erd = 0; emw = 0;
    eill = 0; ehalt = 0; ealu = 0; eidx = -1;
    case (op)
      0, 1, 2, 3, 4: begin
        ecyc = 4; ewr = 1; ealu = op; eidx = fw + 2;
      end
      5: begin ecyc = 5 + md; ewr = 1; ews = 1; erd = md + 1; end
      6: begin ecyc = 4 + md; emw = md + 1; end
      7: begin
        ecyc = 4; ealu = 1; eidx = 2 * fw + 3;
        if (z) npc = b1;
      end
      8: begin ecyc = 5; ewr = 1; ews = 2; end
      9: begin ecyc = 4; npc = b1; end
      10: begin ecyc = 4; ewr = 1; ewa = 4 + ra; ews = 3; end
      15: begin ecyc = 2; ehalt = 1; end
      default: begin ecyc = 2; eill = 1; end
    endcase
    ecyc += fw * len;
    cyc = 0; k = 0; wcnt = 0; mcnt = 0;
    nwr = 0; nrd = 0; nmw = 0; nil = 0; nov = 0; nbad = 0;
    wa = 0; ws = 0; im = 0; aluo = 0;
    forever begin
      if (cyc > 0 && instr_req && k == len) break;
      if (halted) break;
      if (cyc > 40) begin
        chk({nm, ".timeout"}, 32'(cyc), 32'(ecyc));
        break;
      end
      if (wr_en) begin
        nwr++;
        wa = int'(wr_addr);
        ws = int'(wb_sel);
        im = int'(imm);
      end
      if (mem_rd) nrd++;
      if (mem_wr) nmw++;
      if (illegal) nil++;
      if (wr_en && mem_wr) nov++;
      if (k >= 1 && (int'(rd_addr1) != ra || int'(rd_addr2) != rb)) nbad++;
      if (cyc == eidx) aluo = int'(alu_op);
      alu_zero = z;
      if (instr_req) begin
        if (wcnt == fw && k < len) begin
          instr_valid = 1'b1;
          instr = bytes[k];
          k++;
          wcnt = 0;
        end else begin
          instr_valid = 1'b0;
          instr = 8'($urandom);
          wcnt++;
        end
      end else begin
        instr_valid = 1'($urandom_range(0, 1));
        instr = 8'($urandom);
      end
      if (mem_rd || mem_wr) begin
        if (mcnt == md) mem_ready = 1'b1;
        else begin
          mem_ready = 1'b0;
          mcnt++;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      tick();
      cyc++;
    end
    chk({nm, ".cycles"}, 32'(cyc), 32'(ecyc));
    chk({nm, ".pc"}, 32'(pc), 32'(npc));
    chk({nm, ".wr_cnt"}, 32'(nwr), 32'(ewr));
    if (ewr != 0) begin
      chk({nm, ".wr_addr"}, 32'(wa), 32'(ewa));
      chk({nm, ".wb_sel"}, 32'(ws), 32'(ews));
    end
    if (op == 8) chk({nm, ".imm"}, 32'(im), 32'(b1));
    chk({nm, ".mem_rd_cyc"}, 32'(nrd), 32'(erd));
    chk({nm, ".mem_wr_cyc"}, 32'(nmw), 32'(emw));
    chk({nm, ".illegal_cnt"}, 32'(nil), 32'(eill));
    chk({nm, ".wr_memwr_overlap"}, 32'(nov), 32'h0);
    chk({nm, ".rd_addr_stable"}, 32'(nbad), 32'h0);
    chk({nm, ".halted"}, 32'(halted), 32'(ehalt));
    if (eidx >= 0) chk({nm, ".alu_op"}, 32'(aluo), 32'(ealu));
    mpc = npc;
  endtask

  initial begin
    logic [3:0] rop;
    #2;
    do_reset("reset0");

    exec_one("add", 8'h01, 8'h00, 1'b0, 0, 0);
    exec_one("li", 8'h88, 8'h2A, 1'b0, 0, 0);
    exec_one("mvh", 8'hA6, 8'h00, 1'b0, 0, 0);
    exec_one("lw", 8'h51, 8'h00, 1'b0, 0, 3);
    exec_one("sw", 8'h6E, 8'h00, 1'b0, 1, 2);
    exec_one("beq_taken", 8'h70, 8'h40, 1'b1, 0, 0);
    chk("beq_taken_pc", 32'(pc), 32'h40);
    exec_one("beq_not", 8'h70, 8'h40, 1'b0, 1, 0);
    chk("beq_not_pc", 32'(pc), 32'h42);

    exec_one("jmp_fe", 8'h90, 8'hFE, 1'b0, 0, 0);
    exec_one("add_fe", 8'h00, 8'h00, 1'b0, 0, 0);
    exec_one("add_ff", 8'h00, 8'h00, 1'b0, 0, 0);
    chk("fetch_wrap_pc", 32'(pc), 32'h00);
    exec_one("jmp_ff", 8'h90, 8'hFF, 1'b0, 0, 0);
    exec_one("li_wrap", 8'h84, 8'h11, 1'b0, 0, 0);
    chk("fimm_wrap_pc", 32'(pc), 32'h01);

    exec_one("illegal_c3", 8'hC3, 8'h00, 1'b0, 0, 0);

    instr_valid = 1'b0;
    repeat (2) tick();
    chk("pre_reset_req", 32'(instr_req), 32'h1);
    do_reset("reset_mid_fetch");

    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 14));
      exec_one($sformatf("rnd%0d", i), {rop, 4'($urandom)},
               8'($urandom), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    exec_one("halt", 8'hF0, 8'h00, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      instr_valid = 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
      instr = 8'($urandom);
      tick();
      chk("halt_req", 32'(instr_req), 32'h0);
      chk("halt_sticky", 32'(halted), 32'h1);
      chk("halt_pc", 32'(pc), 32'(mpc));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
